// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : Load/store unit; one req/ack memory transaction per instruction.
// Revision : 1.0
// ============================================================================
module lsu #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [2:0]       r_f3, w_f3;
    logic [1:0]       r_off, w_off;

    logic        w_busy, w_done, w_err, w_req, w_we;
    logic [1:0]  w_code;
    logic [31:0] w_rdata, w_addr, w_wdata, w_load, w_lane_wdata;
    logic [3:0]  w_be, w_lane_be;
    logic        w_illegal, w_misal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Unsigned widths are load-only; illegal wins over misaligned.
    assign w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_funct3[2] && req_we);
    assign w_misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    always_comb begin
        w_lane_be    = 4'b1111;
        w_lane_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_lane_be    = 4'b0001 << req_addr[1:0];
                w_lane_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_lane_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: ;
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_f3    = r_f3;
        w_off   = r_off;
        w_busy  = busy;
        w_done  = 1'b0;
        w_rdata = 32'd0;
        w_err   = 1'b0;
        w_code  = 2'b00;
        w_req   = mem_req;
        w_we    = mem_we;
        w_addr  = mem_addr;
        w_wdata = mem_wdata;
        w_be    = mem_be;
        case (r_state)
            S_REQ: begin
                if (mem_ack) begin
                    w_state = S_FIN;
                    w_done  = 1'b1;
                    w_rdata = mem_we ? 32'd0 : w_load;
                    w_req   = 1'b0;
                    w_busy  = 1'b0;
                end else if (r_cnt == c_last) begin
                    w_state = S_FIN;
                    w_err   = 1'b1;
                    w_code  = 2'b10;
                    w_req   = 1'b0;
                    w_busy  = 1'b0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            // IDLE and FIN both accept, which gives back-to-back issue.
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_req   = 1'b0;
                if (req_valid) begin
                    if (w_illegal || w_misal) begin
                        w_state = S_FIN;
                        w_err   = 1'b1;
                        w_code  = w_illegal ? 2'b11 : 2'b01;
                    end else begin
                        w_state = S_REQ;
                        w_busy  = 1'b1;
                        w_req   = 1'b1;
                        w_cnt   = '0;
                        w_f3    = req_funct3;
                        w_off   = req_addr[1:0];
                        w_we    = req_we;
                        w_addr  = {req_addr[31:2], 2'b00};
                        w_wdata = req_we ? w_lane_wdata : 32'd0;
                        w_be    = req_we ? w_lane_be : 4'b0000;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_f3      <= 3'b000;
            r_off     <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= 32'd0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'b0000;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_f3      <= w_f3;
            r_off     <= w_off;
            busy      <= w_busy;
            done      <= w_done;
            rdata     <= w_rdata;
            err       <= w_err;
            err_code  <= w_code;
            mem_req   <= w_req;
            mem_we    <= w_we;
            mem_addr  <= w_addr;
            mem_wdata <= w_wdata;
            mem_be    <= w_be;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Brief    : Scoreboard bench for lsu with a scripted memory responder.
// Revision : 1.0
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [1:0]  err_code;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    typedef struct {
        logic        e;
        logic [1:0]  code;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0, failures = 0, n_res = 0, req_hi = 0;
    int   rcnt = 0, ack_at = 0;
    logic stray = 1'b0;

    lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err), .err_code(err_code),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Acks in the ack_at-th cycle of mem_req; ack_at=0 never acks.
    always @(posedge clk) begin
        #1;
        if (mem_req) rcnt = rcnt + 1;
        else         rcnt = 0;
        mem_ack = stray | (mem_req && (rcnt == ack_at));
    end

    always @(negedge clk) begin
        if (mem_req) req_hi = req_hi + 1;
        if (rst_n && (done || err)) begin
            n_res  = n_res + 1;
            checks = checks + 1;
            if (sb.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_result done=%0b err=%0b code=%b rdata=%h", done, err, err_code, rdata);
            end else begin
                mon_e = sb.pop_front();
                if (err !== mon_e.e || done !== !mon_e.e || err_code !== mon_e.code ||
                    rdata !== mon_e.rd || busy !== 1'b0) begin
                    failures = failures + 1;
                    $display("FAIL result got done=%0b err=%0b code=%b rdata=%h busy=%0b want err=%0b code=%b rdata=%h",
                             done, err, err_code, rdata, busy, mon_e.e, mon_e.code, mon_e.rd);
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        req_hi = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_res(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (n_res >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks = checks + 2;
        if ({busy, done, err, err_code, rdata} !== '0) begin
            failures = failures + 1;
            $display("FAIL reset_core busy=%0b done=%0b err=%0b code=%b rdata=%h want 0", busy, done, err, err_code, rdata);
        end
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
            failures = failures + 1;
            $display("FAIL reset_mem req=%0b we=%0b addr=%h wdata=%h be=%b want 0", mem_req, mem_we, mem_addr, mem_wdata, mem_be);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_byte();
        bit ok;
        int target = n_res + 1;
        ack_at = 1; mem_rdata = 32'h80FF_0000;
        sb.push_back('{1'b0, 2'b00, 32'hFFFF_FF80});
        drive(1'b0, 3'b000, 32'h103, 32'd0);
        @(negedge clk);
        checks = checks + 1;
        if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b0000 || mem_we !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL lb_req req=%0b busy=%0b addr=%h be=%b we=%0b want 1 1 100 0000 0", mem_req, busy, mem_addr, mem_be, mem_we);
        end
        wait_res(target, ok);
        checks = checks + 1;
        if (!ok || req_hi != 1) begin
            failures = failures + 1;
            $display("FAIL lb_done ok=%0b req_cycles=%0d want 1", ok, req_hi);
        end
    endtask

    task automatic test_store_half();
        bit ok;
        int target = n_res + 1;
        ack_at = 4;
        sb.push_back('{1'b0, 2'b00, 32'd0});
        drive(1'b1, 3'b001, 32'h202, 32'h1234_ABCD);
        @(negedge clk);
        checks = checks + 1;
        if (mem_be !== 4'b1100 || mem_wdata !== 32'hABCD_ABCD || mem_we !== 1'b1 || mem_addr !== 32'h200) begin
            failures = failures + 1;
            $display("FAIL sh_lanes be=%b wdata=%h we=%0b addr=%h want 1100 abcdabcd 1 200", mem_be, mem_wdata, mem_we, mem_addr);
        end
        wait_res(target, ok);
        checks = checks + 1;
        if (!ok || req_hi != 4) begin
            failures = failures + 1;
            $display("FAIL sh_done ok=%0b req_cycles=%0d want 4", ok, req_hi);
        end
    endtask

    task automatic test_misaligned();
        bit ok;
        int target = n_res + 2;
        sb.push_back('{1'b1, 2'b01, 32'd0});
        drive(1'b0, 3'b010, 32'h201, 32'd0);
        sb.push_back('{1'b1, 2'b01, 32'd0});
        drive(1'b1, 3'b001, 32'h3, 32'd0);
        wait_res(target, ok);
        checks = checks + 1;
        if (!ok || req_hi != 0) begin
            failures = failures + 1;
            $display("FAIL misaligned ok=%0b req_cycles=%0d want 0", ok, req_hi);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int target = n_res + 1;
        ack_at = 0;
        sb.push_back('{1'b1, 2'b10, 32'd0});
        drive(1'b0, 3'b101, 32'h0, 32'd0);
        wait_res(target, ok);
        checks = checks + 1;
        if (!ok || req_hi != 16 || busy !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL timeout ok=%0b req_cycles=%0d busy=%0b want 16 0", ok, req_hi, busy);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        logic [3:0]  kind [4] = '{4'b0011, 4'b1100, 4'b0111, 4'b1101};
        logic [31:0] adr  [4] = '{32'h0, 32'h0, 32'h3, 32'h1};
        for (int i = 0; i < 4; i++) begin
            int target = n_res + 1;
            sb.push_back('{1'b1, 2'b11, 32'd0});
            drive(kind[i][3], kind[i][2:0], adr[i], 32'd0);
            wait_res(target, ok);
            checks = checks + 1;
            if (!ok || req_hi != 0) begin
                failures = failures + 1;
                $display("FAIL illegal_%0d ok=%0b req_cycles=%0d want 0", i, ok, req_hi);
            end
        end
    endtask

    task automatic test_loads();
        bit ok;
        logic [2:0]  f3  [7] = '{3'b000, 3'b001, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000};
        logic [31:0] adr [7] = '{32'h0, 32'h2, 32'h6, 32'h1, 32'h10, 32'h0, 32'h2};
        logic [31:0] wrd [7] = '{32'h0000_007F, 32'h8001_7FFF, 32'h8001_7FFF, 32'h0000_F000,
                                 32'hDEAD_BEEF, 32'h8001_7FFF, 32'h0080_0000};
        logic [31:0] exp [7] = '{32'h0000_007F, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_00F0,
                                 32'hDEAD_BEEF, 32'h0000_7FFF, 32'hFFFF_FF80};
        for (int i = 0; i < 7; i++) begin
            int target = n_res + 1;
            ack_at = (i % 3) + 1;
            mem_rdata = wrd[i];
            sb.push_back('{1'b0, 2'b00, exp[i]});
            drive(1'b0, f3[i], adr[i], 32'd0);
            wait_res(target, ok);
            checks = checks + 1;
            if (!ok) begin
                failures = failures + 1;
                $display("FAIL load_%0d no completion", i);
            end
        end
    endtask

    task automatic test_stores();
        bit ok;
        logic [2:0]  f3  [4] = '{3'b000, 3'b000, 3'b001, 3'b010};
        logic [31:0] adr [4] = '{32'h2, 32'h3, 32'h8, 32'h4};
        logic [31:0] wd  [4] = '{32'h0000_00AB, 32'h0000_0011, 32'h1234_ABCD, 32'hCAFE_F00D};
        logic [3:0]  be  [4] = '{4'b0100, 4'b1000, 4'b0011, 4'b1111};
        logic [31:0] mw  [4] = '{32'hABAB_ABAB, 32'h1111_1111, 32'hABCD_ABCD, 32'hCAFE_F00D};
        ack_at = 2;
        for (int i = 0; i < 4; i++) begin
            int target = n_res + 1;
            sb.push_back('{1'b0, 2'b00, 32'd0});
            drive(1'b1, f3[i], adr[i], wd[i]);
            @(negedge clk);
            checks = checks + 1;
            if (mem_be !== be[i] || mem_wdata !== mw[i] || mem_addr !== (adr[i] & 32'hFFFF_FFFC)) begin
                failures = failures + 1;
                $display("FAIL store_%0d be=%b wdata=%h addr=%h want %b %h %h", i, mem_be, mem_wdata, mem_addr, be[i], mw[i], adr[i] & 32'hFFFF_FFFC);
            end
            wait_res(target, ok);
            if (!ok) begin
                failures = failures + 1;
                $display("FAIL store_%0d_done no completion", i);
            end
        end
    endtask

    task automatic test_stray_ack();
        int n0 = n_res;
        @(posedge clk); #1;
        stray = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stray = 1'b0;
        repeat (3) @(posedge clk);
        checks = checks + 1;
        if (n_res != n0 || busy !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL stray_ack results=%0d busy=%0b want %0d 0", n_res, busy, n0);
        end
    endtask

    task automatic test_reset_mid();
        int n0 = n_res;
        ack_at = 0;
        drive(1'b0, 3'b010, 32'h40, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks = checks + 1;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL reset_mid req=%0b busy=%0b want 0 0", mem_req, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        checks = checks + 1;
        if (n_res != n0 || mem_req !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL reset_mid_quiet results=%0d req=%0b want %0d 0", n_res, mem_req, n0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int target = n_res + 2;
        ack_at = 1;
        sb.push_back('{1'b0, 2'b00, 32'd0});
        sb.push_back('{1'b0, 2'b00, 32'd0});
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h300; req_wdata = 32'h1111_2222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_addr = 32'h304; req_wdata = 32'h3333_4444;
        @(negedge clk);
        checks = checks + 1;
        if (done !== 1'b1 || mem_req !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL b2b_fin done=%0b req=%0b want 1 0", done, mem_req);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (mem_req !== 1'b1 || mem_addr !== 32'h304 || mem_wdata !== 32'h3333_4444 || mem_be !== 4'b1111) begin
            failures = failures + 1;
            $display("FAIL b2b_second req=%0b addr=%h wdata=%h be=%b want 1 304 33334444 1111", mem_req, mem_addr, mem_wdata, mem_be);
        end
        wait_res(target, ok);
        checks = checks + 1;
        if (!ok) begin
            failures = failures + 1;
            $display("FAIL b2b_done results=%0d want %0d", n_res, target);
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_illegal();
        test_loads();
        test_stores();
        test_stray_ack();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_leftover entries=%0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
